// File: rtl/trap_pkg.sv
// trap_pkg: shared definitions for the machine-mode trap controller.
// Holds the trap FSM state enum, exception/interrupt cause codes, the CSR
// addresses the controller writes, mstatus/mie bit positions and two helper
// functions that compute the mstatus value written on trap entry and on mret.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_W_MEPC    = 3'd1,
    ST_W_MTVAL   = 3'd2,
    ST_W_MSTATUS = 3'd3,
    ST_ASSERT    = 3'd4
  } trap_state_e;

  // Synchronous exception causes
  localparam logic [31:0] CAUSE_ILLEGAL     = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK      = 32'd3;
  localparam logic [31:0] CAUSE_LD_MISALIGN = 32'd4;
  localparam logic [31:0] CAUSE_ST_MISALIGN = 32'd6;
  localparam logic [31:0] CAUSE_ECALL       = 32'd11;

  // Interrupt causes (the interrupt flag is OR-ed in by the arbiter)
  localparam logic [31:0] CAUSE_IRQ_FLAG    = 32'h8000_0000;
  localparam logic [31:0] CAUSE_IRQ_SW      = 32'd3;
  localparam logic [31:0] CAUSE_IRQ_TIMER   = 32'd7;
  localparam logic [31:0] CAUSE_IRQ_EXT     = 32'd11;
  localparam int          FAST_IRQ_BASE     = 16;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Bit positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MSIE_BIT     = 3;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIE_MEIE_BIT     = 11;

  // Trap entry: MPIE takes the old MIE, MIE is cleared
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE_BIT] = s[MSTATUS_MIE_BIT];
    r[MSTATUS_MIE_BIT]  = 1'b0;
    return r;
  endfunction

  // mret: MIE is restored from MPIE, MPIE is set
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE_BIT]  = s[MSTATUS_MPIE_BIT];
    r[MSTATUS_MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: bundles the decode/LSU request side, the CSR snapshot inputs
// and the CSR-write / redirect outputs of the trap controller.
// Modports:
//   master - the pipeline side: drives requests and CSR values, observes outputs
//   slave  - the trap controller itself
interface trap_ctrl_if #(
  parameter int NUM_FAST_IRQ = 15,
  parameter int CSR_ADDR_W   = 32
);

  logic                    inst_valid_i;
  logic [31:0]             inst_addr_i;
  logic                    inst_ecall_i;
  logic                    inst_ebreak_i;
  logic                    inst_illegal_i;
  logic                    inst_mret_i;
  logic [1:0]              mem_misalign_i;
  logic [31:0]             mem_addr_i;
  logic [31:0]             mtvec_i;
  logic [31:0]             mepc_i;
  logic [31:0]             mstatus_i;
  logic [31:0]             mie_i;
  logic [2:0]              irq_i;
  logic [NUM_FAST_IRQ-1:0] irq_fast_i;

  logic                    csr_we_o;
  logic [CSR_ADDR_W-1:0]   csr_waddr_o;
  logic [31:0]             csr_wdata_o;
  logic                    stall_flag_o;
  logic [31:0]             int_addr_o;
  logic                    int_assert_o;

  modport master (
    output inst_valid_i, inst_addr_i, inst_ecall_i, inst_ebreak_i,
           inst_illegal_i, inst_mret_i, mem_misalign_i, mem_addr_i,
           mtvec_i, mepc_i, mstatus_i, mie_i, irq_i, irq_fast_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, stall_flag_o,
           int_addr_o, int_assert_o
  );

  modport slave (
    input  inst_valid_i, inst_addr_i, inst_ecall_i, inst_ebreak_i,
           inst_illegal_i, inst_mret_i, mem_misalign_i, mem_addr_i,
           mtvec_i, mepc_i, mstatus_i, mie_i, irq_i, irq_fast_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, stall_flag_o,
           int_addr_o, int_assert_o
  );

endinterface

// File: rtl/trap_irq_arb.sv
// trap_irq_arb: combinational masked priority encoder for interrupts.
// Ports:
//   irq_i        {external, timer, software} level lines
//   irq_fast_i   fast lines, line i enabled by mie_i[16+i]
//   mie_i        mie CSR
//   global_en_i  mstatus.MIE
//   req_o        an enabled interrupt is pending
//   cause_o      mcause value for the winning interrupt
// Priority: fast (lowest index first) > external > software > timer.
module trap_irq_arb
  import trap_pkg::*;
#(
  parameter int NUM_FAST_IRQ = 15
) (
  input  logic [2:0]              irq_i,
  input  logic [NUM_FAST_IRQ-1:0] irq_fast_i,
  input  logic [31:0]             mie_i,
  input  logic                    global_en_i,
  output logic                    req_o,
  output logic [31:0]             cause_o
);

  // Only some mie bits are enables for lines this block sees.
  logic unused_mie;
  assign unused_mie = ^mie_i;

  // Candidates are visited from lowest to highest priority so that the
  // last match (the highest-priority one) is what remains.
  always_comb begin
    req_o   = 1'b0;
    cause_o = 32'd0;
    if (global_en_i) begin
      if (irq_i[1] && mie_i[MIE_MTIE_BIT]) begin
        req_o   = 1'b1;
        cause_o = CAUSE_IRQ_FLAG | CAUSE_IRQ_TIMER;
      end
      if (irq_i[0] && mie_i[MIE_MSIE_BIT]) begin
        req_o   = 1'b1;
        cause_o = CAUSE_IRQ_FLAG | CAUSE_IRQ_SW;
      end
      if (irq_i[2] && mie_i[MIE_MEIE_BIT]) begin
        req_o   = 1'b1;
        cause_o = CAUSE_IRQ_FLAG | CAUSE_IRQ_EXT;
      end
      for (int i = NUM_FAST_IRQ - 1; i >= 0; i--) begin
        if (irq_fast_i[i] && mie_i[FAST_IRQ_BASE + i]) begin
          req_o   = 1'b1;
          cause_o = CAUSE_IRQ_FLAG | 32'(FAST_IRQ_BASE + i);
        end
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller between decode/LSU and the CSR file.
// Ports:
//   clk, rst_n  core clock, asynchronous active-low reset
//   bus         trap_ctrl_if.slave: instruction/exception requests, CSR
//               snapshots (mtvec/mepc/mstatus/mie), interrupt lines, and the
//               CSR write strobe/address/data, stall request and the
//               one-cycle redirect pulse with its target address.
// A trap writes mcause (request cycle), mepc, mtval, mstatus on consecutive
// cycles and then pulses int_assert_o; mret writes mstatus and pulses on the
// next cycle.
// Build option: TRAP_VECTORED_EN - when defined, mtvec mode 2'b01 dispatches
// interrupts to base + 4*cause[4:0]; otherwise every trap goes to base.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int NUM_FAST_IRQ = 15,
  parameter int CSR_ADDR_W   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  trap_ctrl_if.slave  bus
);

  trap_state_e state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] target_q, target_d;
  logic [31:0] mstatus_q, mstatus_d;

  logic        irq_req;
  logic [31:0] irq_cause;
  logic        req_ok;
  logic        exc_req;
  logic        exc_misalign;
  logic [31:0] exc_cause;
  logic        trap_req;
  logic        mret_req;
  logic [31:0] base_addr;
  logic [31:0] irq_target;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;

  trap_irq_arb #(
    .NUM_FAST_IRQ (NUM_FAST_IRQ)
  ) u_irq_arb (
    .irq_i       (bus.irq_i),
    .irq_fast_i  (bus.irq_fast_i),
    .mie_i       (bus.mie_i),
    .global_en_i (bus.mstatus_i[MSTATUS_MIE_BIT]),
    .req_o       (irq_req),
    .cause_o     (irq_cause)
  );

  assign base_addr = {bus.mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign irq_target = (bus.mtvec_i[1:0] == 2'b01)
                    ? base_addr + {25'd0, irq_cause[4:0], 2'b00}
                    : base_addr;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^bus.mtvec_i[1:0];
  assign irq_target = base_addr;
`endif

  // Synchronous exception selection; misaligned accesses also report the
  // faulting address through mtval.
  always_comb begin
    exc_req      = 1'b1;
    exc_misalign = 1'b0;
    exc_cause    = 32'd0;
    if (bus.inst_illegal_i) begin
      exc_cause = CAUSE_ILLEGAL;
    end else if (bus.inst_ecall_i) begin
      exc_cause = CAUSE_ECALL;
    end else if (bus.inst_ebreak_i) begin
      exc_cause = CAUSE_EBREAK;
    end else if (bus.mem_misalign_i[0]) begin
      exc_cause    = CAUSE_LD_MISALIGN;
      exc_misalign = 1'b1;
    end else if (bus.mem_misalign_i[1]) begin
      exc_cause    = CAUSE_ST_MISALIGN;
      exc_misalign = 1'b1;
    end else begin
      exc_req = 1'b0;
    end
  end

  // Requests only count in IDLE; a trap always beats a simultaneous mret.
  assign req_ok   = bus.inst_valid_i && (state_q == ST_IDLE);
  assign trap_req = req_ok && (exc_req || irq_req);
  assign mret_req = req_ok && bus.inst_mret_i && !trap_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      tval_q    <= 32'd0;
      target_q  <= 32'd0;
      mstatus_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      tval_q    <= tval_d;
      target_q  <= target_d;
      mstatus_q <= mstatus_d;
    end
  end

  // The mcause/mstatus write of the request cycle uses the freshly selected
  // values; later write cycles replay what was latched in IDLE.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    tval_d    = tval_q;
    target_d  = target_q;
    mstatus_d = mstatus_q;
    csr_we    = 1'b0;
    csr_addr  = 12'd0;
    csr_wdata = 32'd0;
    unique case (state_q)
      ST_IDLE: begin
        if (trap_req) begin
          cause_d   = exc_req ? exc_cause : irq_cause;
          epc_d     = bus.inst_addr_i;
          tval_d    = (exc_req && exc_misalign) ? bus.mem_addr_i : 32'd0;
          target_d  = exc_req ? base_addr : irq_target;
          mstatus_d = mstatus_on_trap(bus.mstatus_i);
          csr_we    = 1'b1;
          csr_addr  = CSR_MCAUSE;
          csr_wdata = cause_d;
          state_d   = ST_W_MEPC;
        end else if (mret_req) begin
          target_d  = bus.mepc_i;
          csr_we    = 1'b1;
          csr_addr  = CSR_MSTATUS;
          csr_wdata = mstatus_on_mret(bus.mstatus_i);
          state_d   = ST_ASSERT;
        end
      end
      ST_W_MEPC: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = epc_q;
        state_d   = ST_W_MTVAL;
      end
      ST_W_MTVAL: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MTVAL;
        csr_wdata = tval_q;
        state_d   = ST_W_MSTATUS;
      end
      ST_W_MSTATUS: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_q;
        state_d   = ST_ASSERT;
      end
      ST_ASSERT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.csr_we_o     = csr_we;
  assign bus.csr_waddr_o  = CSR_ADDR_W'(csr_addr);
  assign bus.csr_wdata_o  = csr_wdata;
  assign bus.int_assert_o = (state_q == ST_ASSERT);
  assign bus.int_addr_o   = target_q;
  assign bus.stall_flag_o = (state_q == ST_W_MEPC) || (state_q == ST_W_MTVAL) ||
                            (state_q == ST_W_MSTATUS) || trap_req ||
                            (bus.inst_mret_i && bus.inst_valid_i);

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: self-checking bench for trap_ctrl. Directed cases from the
// feature list followed by randomized requests, all compared against a
// behavioural model that derives cause, mtval, target and mstatus from the
// architectural trap rules. Honours TRAP_VECTORED_EN like the design.
module tb_trap_ctrl;

  localparam int NF = 15;
  localparam int AW = 32;

  logic clk;
  logic rst_n;

  trap_ctrl_if #(.NUM_FAST_IRQ(NF), .CSR_ADDR_W(AW)) bus ();

  trap_ctrl #(
    .NUM_FAST_IRQ (NF),
    .CSR_ADDR_W   (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [31:0]   pc;
    logic          ecall;
    logic          ebreak;
    logic          illegal;
    logic          mret;
    logic [1:0]    mis;
    logic [31:0]   maddr;
    logic [31:0]   mtvec;
    logic [31:0]   mepc;
    logic [31:0]   mstatus;
    logic [31:0]   mie;
    logic [2:0]    irq;
    logic [NF-1:0] fast;
  } stim_t;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] lastTarget  = 32'd0;
  logic [31:0] seenCause, seenEpc, seenMtval, seenMst, seenTarget;
  stim_t       s;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t r;
    r.valid = 1'b0; r.pc = 32'd0; r.ecall = 1'b0; r.ebreak = 1'b0;
    r.illegal = 1'b0; r.mret = 1'b0; r.mis = 2'b00; r.maddr = 32'd0;
    r.mtvec = 32'd0; r.mepc = 32'd0; r.mstatus = 32'd0; r.mie = 32'd0;
    r.irq = 3'd0; r.fast = '0;
    return r;
  endfunction

  function automatic stim_t randStim();
    stim_t r;
    r.valid   = ($urandom_range(9) != 0);
    r.pc      = $urandom;
    r.ecall   = ($urandom_range(7) == 0);
    r.ebreak  = ($urandom_range(7) == 0);
    r.illegal = ($urandom_range(7) == 0);
    r.mret    = ($urandom_range(4) == 0);
    r.mis     = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
    r.maddr   = $urandom;
    r.mtvec   = $urandom;
    if ($urandom_range(2) == 0) r.mtvec[1:0] = 2'b01;
    r.mepc    = $urandom;
    r.mstatus = $urandom;
    r.mie     = $urandom;
    r.irq     = ($urandom_range(1) == 0) ? 3'($urandom) : 3'd0;
    r.fast    = NF'($urandom & $urandom);
    return r;
  endfunction

  task automatic drive(input stim_t d);
    bus.inst_valid_i   = d.valid;
    bus.inst_addr_i    = d.pc;
    bus.inst_ecall_i   = d.ecall;
    bus.inst_ebreak_i  = d.ebreak;
    bus.inst_illegal_i = d.illegal;
    bus.inst_mret_i    = d.mret;
    bus.mem_misalign_i = d.mis;
    bus.mem_addr_i     = d.maddr;
    bus.mtvec_i        = d.mtvec;
    bus.mepc_i         = d.mepc;
    bus.mstatus_i      = d.mstatus;
    bus.mie_i          = d.mie;
    bus.irq_i          = d.irq;
    bus.irq_fast_i     = d.fast;
  endtask

  // Reference model: kind 0 = nothing, 1 = trap, 2 = mret
  function automatic void refModel(input stim_t d, output int kind, output logic [31:0] cause,
                                   output logic [31:0] tval, output logic [31:0] target,
                                   output logic [31:0] mst);
    logic [31:0] base;
    bit          isIrq;
    base   = d.mtvec & 32'hFFFF_FFFC;
    kind   = 0;
    cause  = 0;
    tval   = 0;
    target = 0;
    mst    = 0;
    isIrq  = 0;
    if (!d.valid) return;
    if (d.illegal)      cause = 2;
    else if (d.ecall)   cause = 11;
    else if (d.ebreak)  cause = 3;
    else if (d.mis[0])  begin cause = 4; tval = d.maddr; end
    else if (d.mis[1])  begin cause = 6; tval = d.maddr; end
    if (cause != 0) begin
      kind = 1;
    end else if (d.mstatus[3]) begin
      for (int i = 0; i < NF; i++) begin
        if (kind == 0 && d.fast[i] && d.mie[16 + i]) begin
          kind = 1; cause = 32'(16 + i);
        end
      end
      if (kind == 0 && d.irq[2] && d.mie[11]) begin kind = 1; cause = 11; end
      if (kind == 0 && d.irq[0] && d.mie[3])  begin kind = 1; cause = 3;  end
      if (kind == 0 && d.irq[1] && d.mie[7])  begin kind = 1; cause = 7;  end
      isIrq = (kind == 1);
    end
    if (kind == 1) begin
      target = base;
      if (isIrq) begin
`ifdef TRAP_VECTORED_EN
        if (d.mtvec[1:0] == 2'b01) target = base + 4 * (cause % 32);
`endif
        cause = cause + 32'h8000_0000;
      end
      mst = d.mstatus;
      mst[7] = d.mstatus[3];
      mst[3] = 1'b0;
    end else if (d.mret) begin
      kind   = 2;
      target = d.mepc;
      mst    = d.mstatus;
      mst[3] = d.mstatus[7];
      mst[7] = 1'b1;
    end
  endfunction

  // Drives one request in IDLE, then follows the whole trap/mret sequence
  // with random junk on the inputs (which the design must ignore).
  task automatic applyStimulus(input stim_t d);
    int          kind;
    logic [31:0] cause, tval, target, mst;
    logic [11:0] addrs [3];
    logic [31:0] datas [3];
    refModel(d, kind, cause, tval, target, mst);
    @(negedge clk);
    drive(d);
    #1;
    if (kind == 0) begin
      checkOutput("idle_stall", 32'(bus.stall_flag_o), 32'd0);
      checkOutput("idle_we", 32'(bus.csr_we_o), 32'd0);
      checkOutput("idle_wdata", bus.csr_wdata_o, 32'd0);
      checkOutput("idle_assert", 32'(bus.int_assert_o), 32'd0);
      checkOutput("idle_addr", bus.int_addr_o, lastTarget);
      @(posedge clk);
      return;
    end
    checkOutput("req_stall", 32'(bus.stall_flag_o), 32'd1);
    checkOutput("req_we", 32'(bus.csr_we_o), 32'd1);
    checkOutput("req_assert", 32'(bus.int_assert_o), 32'd0);
    if (kind == 1) begin
      checkOutput("mcause_addr", bus.csr_waddr_o, 32'h342);
      checkOutput("mcause_data", bus.csr_wdata_o, cause);
      seenCause = bus.csr_wdata_o;
      addrs[0] = 12'h341; datas[0] = d.pc;
      addrs[1] = 12'h343; datas[1] = tval;
      addrs[2] = 12'h300; datas[2] = mst;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1 drive(randStim());
        @(negedge clk);
        checkOutput($sformatf("wr%0d_we", k), 32'(bus.csr_we_o), 32'd1);
        checkOutput($sformatf("wr%0d_addr", k), bus.csr_waddr_o, 32'(addrs[k]));
        checkOutput($sformatf("wr%0d_data", k), bus.csr_wdata_o, datas[k]);
        checkOutput($sformatf("wr%0d_stall", k), 32'(bus.stall_flag_o), 32'd1);
        checkOutput($sformatf("wr%0d_assert", k), 32'(bus.int_assert_o), 32'd0);
        if (k == 0) seenEpc = bus.csr_wdata_o;
        if (k == 1) seenMtval = bus.csr_wdata_o;
        if (k == 2) seenMst = bus.csr_wdata_o;
      end
    end else begin
      checkOutput("mret_addr", bus.csr_waddr_o, 32'h300);
      checkOutput("mret_data", bus.csr_wdata_o, mst);
      seenMst = bus.csr_wdata_o;
    end
    @(posedge clk);
    #1 drive(randStim());
    @(negedge clk);
    checkOutput("pulse_assert", 32'(bus.int_assert_o), 32'd1);
    checkOutput("pulse_target", bus.int_addr_o, target);
    checkOutput("pulse_we", 32'(bus.csr_we_o), 32'd0);
    checkOutput("pulse_stall", 32'(bus.stall_flag_o), 32'(bus.inst_mret_i & bus.inst_valid_i));
    seenTarget = bus.int_addr_o;
    lastTarget = target;
    @(posedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_we"}, 32'(bus.csr_we_o), 32'd0);
    checkOutput({tag, "_waddr"}, bus.csr_waddr_o, 32'd0);
    checkOutput({tag, "_wdata"}, bus.csr_wdata_o, 32'd0);
    checkOutput({tag, "_assert"}, 32'(bus.int_assert_o), 32'd0);
    checkOutput({tag, "_addr"}, bus.int_addr_o, 32'd0);
    checkOutput({tag, "_stall"}, 32'(bus.stall_flag_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(idleStim());
    repeat (3) @(posedge clk);
    #1 checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ecall at 0x100
    s = idleStim();
    s.valid = 1; s.pc = 32'h100; s.ecall = 1; s.mtvec = 32'h8000_0000; s.mstatus = 32'h8;
    applyStimulus(s);
    checkOutput("plan_ecall_cause", seenCause, 32'hB);
    checkOutput("plan_ecall_mepc", seenEpc, 32'h100);
    checkOutput("plan_ecall_mtval", seenMtval, 32'h0);
    checkOutput("plan_ecall_mst", seenMst, 32'h80);
    checkOutput("plan_ecall_target", seenTarget, 32'h8000_0000);

    // load misaligned
    s = idleStim();
    s.valid = 1; s.pc = 32'h204; s.mis = 2'b01; s.maddr = 32'h2003; s.mtvec = 32'h3000;
    applyStimulus(s);
    checkOutput("plan_lmis_cause", seenCause, 32'h4);
    checkOutput("plan_lmis_mtval", seenMtval, 32'h2003);

    // illegal and ecall together
    s = idleStim();
    s.valid = 1; s.pc = 32'h208; s.illegal = 1; s.ecall = 1; s.mis = 2'b10; s.maddr = 32'h55;
    applyStimulus(s);
    checkOutput("plan_illegal_cause", seenCause, 32'h2);
    checkOutput("plan_illegal_mtval", seenMtval, 32'h0);

    // timer interrupt, mtvec mode 01
    s = idleStim();
    s.valid = 1; s.pc = 32'h300; s.mtvec = 32'h1001; s.mstatus = 32'h8;
    s.mie = 32'h80; s.irq = 3'b010;
    applyStimulus(s);
    checkOutput("plan_timer_cause", seenCause, 32'h8000_0007);
`ifdef TRAP_VECTORED_EN
    checkOutput("plan_timer_target", seenTarget, 32'h101C);
`else
    checkOutput("plan_timer_target", seenTarget, 32'h1000);
`endif

    // fast 2 and 5 plus external pending
    s = idleStim();
    s.valid = 1; s.pc = 32'h310; s.mtvec = 32'h1000; s.mstatus = 32'h8;
    s.mie = (32'd1 << 18) | (32'd1 << 21) | (32'd1 << 11);
    s.irq = 3'b100; s.fast = NF'(15'b000_0000_0010_0100);
    applyStimulus(s);
    checkOutput("plan_fast2_cause", seenCause, 32'h8000_0012);
    s.mie[18] = 1'b0;
    applyStimulus(s);
    checkOutput("plan_fast5_cause", seenCause, 32'h8000_0015);

    // interrupts globally disabled: nothing happens
    s = idleStim();
    s.valid = 1; s.pc = 32'h320; s.mstatus = 32'h0; s.mie = 32'h80; s.irq = 3'b010;
    applyStimulus(s);

    // mret
    s = idleStim();
    s.valid = 1; s.pc = 32'h330; s.mret = 1; s.mstatus = 32'h80; s.mepc = 32'h400;
    applyStimulus(s);
    checkOutput("plan_mret_mst", seenMst, 32'h88);
    checkOutput("plan_mret_target", seenTarget, 32'h400);

    // mret with pending timer interrupt: interrupt taken at mret's PC
    s = idleStim();
    s.valid = 1; s.pc = 32'h340; s.mret = 1; s.mstatus = 32'h88; s.mepc = 32'h400;
    s.mie = 32'h80; s.irq = 3'b010; s.mtvec = 32'h2000;
    applyStimulus(s);
    checkOutput("plan_mretirq_cause", seenCause, 32'h8000_0007);
    checkOutput("plan_mretirq_mepc", seenEpc, 32'h340);

    // reset during W_MTVAL
    s = idleStim();
    s.valid = 1; s.pc = 32'h500; s.ecall = 1; s.mtvec = 32'h4000; s.mstatus = 32'h8;
    @(negedge clk);
    drive(s);
    @(posedge clk);
    #1 drive(idleStim());
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkAllZero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    lastTarget = 32'd0;
    applyStimulus(s);
    checkOutput("plan_postreset_cause", seenCause, 32'hB);
    checkOutput("plan_postreset_target", seenTarget, 32'h4000);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      applyStimulus(randStim());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name:
trap_ctrl

Overview:
Parametrised machine-mode trap controller; the next generation of the core's exception unit. Sits between decode/LSU and the CSR file; adds illegal/misaligned exceptions, mtval, MPIE save/restore on mret, a configurable fast-IRQ count with per-line enables, and optional vectored dispatch.

Parameters:
NUM_FAST_IRQ, 15, number of fast interrupt lines (1..16); line i has cause 16+i and enable mie[16+i]
CSR_ADDR_W, 32, width of csr_waddr_o; the 12-bit CSR address is zero-extended into it

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
inst_valid_i  input  1  instruction in execute stage is valid
inst_addr_i  input  32  PC of that instruction
inst_ecall_i  input  1  ecall
inst_ebreak_i  input  1  ebreak
inst_illegal_i  input  1  illegal instruction
inst_mret_i  input  1  mret
mem_misalign_i  input  2  [0] load misaligned, [1] store misaligned
mem_addr_i  input  32  faulting data address
mtvec_i  input  32  mtvec CSR
mepc_i  input  32  mepc CSR
mstatus_i  input  32  mstatus CSR (MIE bit 3, MPIE bit 7)
mie_i  input  32  mie CSR
irq_i  input  3  {external, timer, software} level interrupts
irq_fast_i  input  NUM_FAST_IRQ  fast interrupts, level
csr_we_o  output  1  CSR write strobe
csr_waddr_o  output  CSR_ADDR_W  CSR write address
csr_wdata_o  output  32  CSR write data
stall_flag_o  output  1  pipeline hold request
int_addr_o  output  32  redirect target
int_assert_o  output  1  one-cycle redirect pulse

Behaviour:
- Reset (async, any state): state IDLE; latched cause/epc/tval/target = 0; csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0, int_assert_o=0, int_addr_o=0.
- Requests sampled only in IDLE and only with inst_valid_i=1; irq lines are level, never latched.
- Priority: illegal(2) > ecall(11) > ebreak(3) > load misalign(4) > store misalign(6) > interrupts (only if mstatus.MIE=1): fast, lowest enabled index first (cause 0x8000_0000|(16+i)) > external(11, mie[11]) > software(3, mie[3]) > timer(7, mie[7]) > mret.
- Trap FSM: IDLE -(trap)-> W_MEPC -> W_MTVAL -> W_MSTATUS -> ASSERT -> IDLE. IDLE cycle writes mcause; W_MEPC writes latched inst_addr_i; W_MTVAL writes mem_addr_i for misalign, else 0; W_MSTATUS writes mstatus with MPIE<=MIE, MIE<=0 (other bits unchanged).
- mret: IDLE writes mstatus with MIE<=MPIE, MPIE<=1; target=mepc_i; -> ASSERT.
- mret plus pending interrupt in same cycle: interrupt wins, mepc = mret's PC (mret re-executes).
- Target: base={mtvec_i[31:2],2'b00}; exceptions always base; interrupts base, or base+4*cause[4:0] under vectored mode (see feature). mtvec mode 2'b1x: direct.
- int_assert_o=1 only in ASSERT (exactly one cycle); int_addr_o holds the latched target. Trap latency: pulse 4 cycles after request cycle; mret: 1 cycle.
- stall_flag_o (combinational) = state in {W_MEPC,W_MTVAL,W_MSTATUS} | qualified trap request | (inst_mret_i & inst_valid_i).
- All inputs ignored outside IDLE; unused FSM encodings return to IDLE.

Optional Feature:
TRAP_VECTORED_EN: defined -> mtvec_i[1:0]==2'b01 dispatches interrupts to base+4*cause[4:0]; undefined -> mode bits ignored, all traps go to base.

Decomposition:
Package trap_pkg: FSM state enum, cause codes, CSR addresses (MCAUSE/MEPC/MTVAL/MSTATUS), mstatus bit indices.
Sub-module trap_irq_arb: combinational masked priority encoder for irq_i/irq_fast_i -> req, cause.

Test Plan:
ecall at PC 0x100, mtvec 0x8000_0000, mstatus 0x8 -> writes mcause 0xB, mepc 0x100, mtval 0, mstatus 0x80; int_addr_o 0x8000_0000, pulse on 4th cycle after request.
Load misalign, mem_addr_i 0x2003 -> mcause 0x4, mtval 0x2003; illegal+ecall same cycle -> mcause 0x2.
mtvec 0x1001, timer irq, mie[7]=1, MIE=1 -> mcause 0x8000_0007, target 0x101C with macro, 0x1000 without.
irq_fast_i[2],[5] and external set, mie[18],[21],[11]=1 -> mcause 0x8000_0012; with mie[18]=0 -> 0x8000_0015.
MIE=0, timer pending -> no stall, no CSR write; mret, mstatus 0x80, mepc 0x400 -> writes 0x88, int_addr_o 0x400 next cycle.
rst_n low during W_MTVAL -> all outputs 0 immediately, IDLE; new ecall afterwards traps normally.
